// File: rtl/vanilla_remote_load_latency_monitor.sv
// Scoreboard-side latency monitor: timestamps long-latency issues per destination register
// and emits {fp, rd, class, latency} records through a buffered valid/yumi stream on clear.
module vanilla_remote_load_latency_monitor #(
  parameter int unsigned els_p       = 8,
  parameter int unsigned ctr_width_p = 32,
  parameter int unsigned cnt_width_p = 16,
  localparam int unsigned reg_addr_width_lp = 5
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         issue_v_i,
  input  logic                         issue_fp_i,
  input  logic [reg_addr_width_lp-1:0] issue_rd_i,
  input  logic [2:0]                   issue_class_i,
  input  logic                         int_sb_clear_i,
  input  logic [reg_addr_width_lp-1:0] int_sb_clear_id_i,
  input  logic                         float_sb_clear_i,
  input  logic [reg_addr_width_lp-1:0] float_sb_clear_id_i,
  output logic                         rec_v_o,
  output logic                         rec_fp_o,
  output logic [reg_addr_width_lp-1:0] rec_rd_o,
  output logic [2:0]                   rec_class_o,
  output logic [ctr_width_p-1:0]       rec_latency_o,
  input  logic                         rec_yumi_i,
  output logic [6:0]                   outstanding_o,
  output logic [cnt_width_p-1:0]       orphan_count_o,
  output logic [cnt_width_p-1:0]       drop_count_o,
  output logic                         error_o
);

  localparam int unsigned ptr_w_lp   = $clog2(els_p);
  localparam int unsigned entries_lp = 2 ** (reg_addr_width_lp + 1);

  typedef struct packed {
    logic                         fp;
    logic [reg_addr_width_lp-1:0] rd;
    logic [2:0]                   cls;
    logic [ctr_width_p-1:0]       lat;
  } rec_t;

  logic [ctr_width_p-1:0] now_q;
  logic [entries_lp-1:0]  valid_q, valid_d;
  logic [2:0]             class_q [entries_lp];
  logic [ctr_width_p-1:0] ts_q    [entries_lp];
  rec_t                   mem_q   [els_p];
  logic [ptr_w_lp-1:0]    rd_ptr_q, wr_ptr_q;
  logic [ptr_w_lp:0]      count_q, count_d, free_space;
  logic [cnt_width_p-1:0] orphan_q, drop_q;
  logic                   error_q;

  logic [reg_addr_width_lp:0] iss_idx, int_idx, flt_idx;
  logic int_hit, flt_hit, int_orphan, flt_orphan, err_set;
  logic pop, push_int, push_flt;
  rec_t int_rec, flt_rec;

  function automatic logic [cnt_width_p-1:0] sat_add(input logic [cnt_width_p-1:0] a,
                                                     input logic [1:0] b);
    logic [cnt_width_p:0] s;
    s = {1'b0, a} + (cnt_width_p + 1)'(b);
    return s[cnt_width_p] ? '1 : s[cnt_width_p-1:0];
  endfunction

  always_comb begin
    iss_idx    = {issue_fp_i, issue_rd_i};
    int_idx    = {1'b0, int_sb_clear_id_i};
    flt_idx    = {1'b1, float_sb_clear_id_i};
    int_hit    = int_sb_clear_i & valid_q[int_idx];
    flt_hit    = float_sb_clear_i & valid_q[flt_idx];
    int_orphan = int_sb_clear_i & ~valid_q[int_idx];
    flt_orphan = float_sb_clear_i & ~valid_q[flt_idx];
    // A clear of the same register in this cycle retires the old entry first.
    err_set = issue_v_i & valid_q[iss_idx]
            & ~(int_hit & (iss_idx == int_idx)) & ~(flt_hit & (iss_idx == flt_idx));

    int_rec = '{fp: 1'b0, rd: int_sb_clear_id_i, cls: class_q[int_idx],
                lat: now_q - ts_q[int_idx]};
    flt_rec = '{fp: 1'b1, rd: float_sb_clear_id_i, cls: class_q[flt_idx],
                lat: now_q - ts_q[flt_idx]};

    // Free space counts the slot released by this cycle's pop; int record wins a lone slot.
    pop        = rec_yumi_i & (count_q != '0);
    free_space = (ptr_w_lp + 1)'(els_p) - count_q + (ptr_w_lp + 1)'(pop);
    push_int   = int_hit & (free_space != '0);
    push_flt   = flt_hit & (free_space > (ptr_w_lp + 1)'(push_int));
    count_d    = count_q - (ptr_w_lp + 1)'(pop) + (ptr_w_lp + 1)'(push_int)
               + (ptr_w_lp + 1)'(push_flt);

    valid_d = valid_q;
    if (int_sb_clear_i)   valid_d[int_idx] = 1'b0;
    if (float_sb_clear_i) valid_d[flt_idx] = 1'b0;
    if (issue_v_i)        valid_d[iss_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      now_q    <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= '0;
      drop_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      now_q    <= now_q + 1'b1;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_q + ptr_w_lp'(pop);
      wr_ptr_q <= wr_ptr_q + ptr_w_lp'(push_int) + ptr_w_lp'(push_flt);
      count_q  <= count_d;
      orphan_q <= sat_add(orphan_q, {1'b0, int_orphan} + {1'b0, flt_orphan});
      drop_q   <= sat_add(drop_q, {1'b0, int_hit & ~push_int} + {1'b0, flt_hit & ~push_flt});
      error_q  <= error_q | err_set;
    end
  end

  // Payload storage needs no reset: valid bits and the FIFO count gate every use.
  always_ff @(posedge clk_i) begin
    if (issue_v_i) begin
      class_q[iss_idx] <= issue_class_i;
      ts_q[iss_idx]    <= now_q;
    end
    if (push_int) mem_q[wr_ptr_q] <= int_rec;
    if (push_flt) mem_q[wr_ptr_q + ptr_w_lp'(push_int)] <= flt_rec;
  end

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < int'(entries_lp); i++) outstanding_o += 7'(valid_q[i]);
  end

  assign rec_v_o        = (count_q != '0);
  assign rec_fp_o       = mem_q[rd_ptr_q].fp;
  assign rec_rd_o       = mem_q[rd_ptr_q].rd;
  assign rec_class_o    = mem_q[rd_ptr_q].cls;
  assign rec_latency_o  = mem_q[rd_ptr_q].lat;
  assign orphan_count_o = orphan_q;
  assign drop_count_o   = drop_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_vanilla_remote_load_latency_monitor.sv
// Directed bench for the latency monitor; narrow counters make wrap and saturation reachable.
module tb_vanilla_remote_load_latency_monitor;
  localparam int unsigned CtrW = 8;
  localparam int unsigned CntW = 3;
  localparam int unsigned Els  = 8;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            issue_v_i, issue_fp_i;
  logic [4:0]      issue_rd_i;
  logic [2:0]      issue_class_i;
  logic            int_sb_clear_i, float_sb_clear_i;
  logic [4:0]      int_sb_clear_id_i, float_sb_clear_id_i;
  logic            rec_v_o, rec_fp_o, rec_yumi_i;
  logic [4:0]      rec_rd_o;
  logic [2:0]      rec_class_o;
  logic [CtrW-1:0] rec_latency_o;
  logic [6:0]      outstanding_o;
  logic [CntW-1:0] orphan_count_o, drop_count_o;
  logic            error_o;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  vanilla_remote_load_latency_monitor #(
    .els_p      (Els),
    .ctr_width_p(CtrW),
    .cnt_width_p(CntW)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .issue_v_i          (issue_v_i),
    .issue_fp_i         (issue_fp_i),
    .issue_rd_i         (issue_rd_i),
    .issue_class_i      (issue_class_i),
    .int_sb_clear_i     (int_sb_clear_i),
    .int_sb_clear_id_i  (int_sb_clear_id_i),
    .float_sb_clear_i   (float_sb_clear_i),
    .float_sb_clear_id_i(float_sb_clear_id_i),
    .rec_v_o            (rec_v_o),
    .rec_fp_o           (rec_fp_o),
    .rec_rd_o           (rec_rd_o),
    .rec_class_o        (rec_class_o),
    .rec_latency_o      (rec_latency_o),
    .rec_yumi_i         (rec_yumi_i),
    .outstanding_o      (outstanding_o),
    .orphan_count_o     (orphan_count_o),
    .drop_count_o       (drop_count_o),
    .error_o            (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    edges++;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    edges   = 0;
  endtask

  task automatic issue(input logic fp, input logic [4:0] rd, input logic [2:0] cls);
    issue_v_i = 1'b1; issue_fp_i = fp; issue_rd_i = rd; issue_class_i = cls;
    tick();
    issue_v_i = 1'b0;
  endtask

  task automatic clr_int(input logic [4:0] rd);
    int_sb_clear_i = 1'b1; int_sb_clear_id_i = rd;
    tick();
    int_sb_clear_i = 1'b0;
  endtask

  task automatic pop();
    rec_yumi_i = 1'b1;
    tick();
    rec_yumi_i = 1'b0;
  endtask

  task automatic chk_rec(input string tag, input logic fp, input logic [4:0] rd,
                         input logic [2:0] cls, input logic [CtrW-1:0] lat);
    chk({tag, ".v"}, 32'(rec_v_o), 32'd1);
    chk({tag, ".fp"}, 32'(rec_fp_o), 32'(fp));
    chk({tag, ".rd"}, 32'(rec_rd_o), 32'(rd));
    chk({tag, ".class"}, 32'(rec_class_o), 32'(cls));
    chk({tag, ".lat"}, 32'(rec_latency_o), 32'(lat));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b0; issue_v_i = 1'b0; issue_fp_i = 1'b0; issue_rd_i = '0; issue_class_i = '0;
    int_sb_clear_i = 1'b0; int_sb_clear_id_i = '0; float_sb_clear_i = 1'b0;
    float_sb_clear_id_i = '0; rec_yumi_i = 1'b0;

    do_reset();
    chk("rst.rec_v", 32'(rec_v_o), 0);
    chk("rst.outstanding", 32'(outstanding_o), 0);
    chk("rst.orphan", 32'(orphan_count_o), 0);
    chk("rst.drop", 32'(drop_count_o), 0);
    chk("rst.error", 32'(error_o), 0);

    // Single dram load, latency 100.
    issue(1'b0, 5'd5, 3'd1);
    chk("t1.outstanding1", 32'(outstanding_o), 1);
    chk("t1.no_rec_yet", 32'(rec_v_o), 0);
    repeat (99) tick();
    clr_int(5'd5);
    chk_rec("t1.rec", 1'b0, 5'd5, 3'd1, 8'd100);
    chk("t1.outstanding0", 32'(outstanding_o), 0);
    pop();
    chk("t1.empty", 32'(rec_v_o), 0);

    // f3 and x3 cleared together: int record first.
    issue(1'b1, 5'd3, 3'd7);
    issue(1'b0, 5'd3, 3'd0);
    chk("t2.outstanding2", 32'(outstanding_o), 2);
    tick();
    tick();
    int_sb_clear_i = 1'b1; int_sb_clear_id_i = 5'd3;
    float_sb_clear_i = 1'b1; float_sb_clear_id_i = 5'd3;
    tick();
    int_sb_clear_i = 1'b0; float_sb_clear_i = 1'b0;
    chk_rec("t2.int", 1'b0, 5'd3, 3'd0, 8'd3);
    chk("t2.outstanding0", 32'(outstanding_o), 0);
    pop();
    chk_rec("t2.flt", 1'b1, 5'd3, 3'd7, 8'd4);
    pop();
    chk("t2.empty", 32'(rec_v_o), 0);

    // Orphan clear and double issue.
    clr_int(5'd7);
    chk("t3.orphan", 32'(orphan_count_o), 1);
    chk("t3.no_rec", 32'(rec_v_o), 0);
    issue(1'b0, 5'd9, 3'd2);
    chk("t3.err0", 32'(error_o), 0);
    issue(1'b0, 5'd9, 3'd2);
    chk("t3.err1", 32'(error_o), 1);
    chk("t3.outstanding1", 32'(outstanding_o), 1);
    clr_int(5'd9);
    chk_rec("t3.rec", 1'b0, 5'd9, 3'd2, 8'd1);
    pop();
    tick();
    chk("t3.err_sticky", 32'(error_o), 1);
    chk("t3.orphan_hold", 32'(orphan_count_o), 1);

    // Overflow: 9 clears into 8 slots, then push while full alongside a pop.
    do_reset();
    chk("t4.err_cleared", 32'(error_o), 0);
    for (int i = 0; i < 9; i++) issue(1'b0, 5'(10 + i), 3'd2);
    issue(1'b0, 5'd20, 3'd4);
    for (int i = 0; i < 9; i++) clr_int(5'(10 + i));
    chk("t4.drop1", 32'(drop_count_o), 1);
    chk_rec("t4.head", 1'b0, 5'd10, 3'd2, 8'd10);
    int_sb_clear_i = 1'b1; int_sb_clear_id_i = 5'd20; rec_yumi_i = 1'b1;
    tick();
    int_sb_clear_i = 1'b0; rec_yumi_i = 1'b0;
    chk("t4.drop_full_pop", 32'(drop_count_o), 1);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) chk_rec($sformatf("t4.drain%0d", i), 1'b0, 5'(11 + i), 3'd2, 8'd10);
      else       chk_rec("t4.drain7", 1'b0, 5'd20, 3'd4, 8'd10);
      pop();
    end
    chk("t4.empty", 32'(rec_v_o), 0);
    chk("t4.outstanding0", 32'(outstanding_o), 0);
    chk("t4.orphan0", 32'(orphan_count_o), 0);

    // Counter wrap, then same-cycle clear + issue on x4.
    do_reset();
    while (edges != 253) tick();
    issue(1'b0, 5'd4, 3'd1);
    repeat (4) tick();
    int_sb_clear_i = 1'b1; int_sb_clear_id_i = 5'd4;
    issue_v_i = 1'b1; issue_fp_i = 1'b0; issue_rd_i = 5'd4; issue_class_i = 3'd3;
    tick();
    int_sb_clear_i = 1'b0; issue_v_i = 1'b0;
    chk_rec("t5.wrap", 1'b0, 5'd4, 3'd1, 8'd5);
    chk("t5.err0", 32'(error_o), 0);
    chk("t5.outstanding1", 32'(outstanding_o), 1);
    pop();
    clr_int(5'd4);
    chk_rec("t5.reissued", 1'b0, 5'd4, 3'd3, 8'd2);
    pop();

    // Async reset mid-cycle with pending entries and records.
    issue(1'b0, 5'd1, 3'd0);
    issue(1'b0, 5'd2, 3'd0);
    issue(1'b1, 5'd1, 3'd7);
    issue(1'b0, 5'd6, 3'd1);
    issue(1'b0, 5'd8, 3'd1);
    clr_int(5'd6);
    clr_int(5'd8);
    chk("t6.outstanding3", 32'(outstanding_o), 3);
    chk("t6.rec_v1", 32'(rec_v_o), 1);
    #3;
    reset_i = 1'b1;
    #1;
    chk("t6.async_rec_v", 32'(rec_v_o), 0);
    chk("t6.async_outstanding", 32'(outstanding_o), 0);
    tick();
    reset_i = 1'b0;
    edges = 0;
    int_sb_clear_i = 1'b1; int_sb_clear_id_i = 5'd1;
    float_sb_clear_i = 1'b1; float_sb_clear_id_i = 5'd1;
    tick();
    int_sb_clear_i = 1'b0; float_sb_clear_i = 1'b0;
    chk("t6.orphan2", 32'(orphan_count_o), 2);
    clr_int(5'd2);
    chk("t6.orphan3", 32'(orphan_count_o), 3);
    chk("t6.no_rec", 32'(rec_v_o), 0);
    int_sb_clear_i = 1'b1; float_sb_clear_i = 1'b1;
    repeat (2) tick();
    chk("t6.orphan7", 32'(orphan_count_o), 7);
    tick();
    int_sb_clear_i = 1'b0; float_sb_clear_i = 1'b0;
    chk("t6.orphan_sat", 32'(orphan_count_o), 7);
    chk("t6.drop0", 32'(drop_count_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vanilla_remote_load_latency_monitor.md
# vanilla_remote_load_latency_monitor

Testbench-side monitor that sits at the completion end of the vanilla core's scoreboard protocol. It records each long-latency issue event (remote load, AMO, idiv, fdiv/fsqrt) per destination register with a timestamp. When the matching scoreboard clear (writeback) arrives, it emits one latency record through a buffered valid/yumi stream for profiling and checking. It also counts protocol anomalies: orphan clears, double issues and record drops.

## Interface
Parameters:
- els_p, 8 — record FIFO depth; power of two, ≥2
- ctr_width_p, 32 — timestamp/latency width
- cnt_width_p, 16 — anomaly counter width (saturating)
- reg_addr_width_lp, 5 — register index width (32 int + 32 float regs)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- issue_v_i  in  1  long-latency op issued this cycle (already qualified by ~stall/~flush)
- issue_fp_i  in  1  destination is float regfile
- issue_rd_i  in  5  destination register
- issue_class_i  in  3  0 idiv, 1 dram load, 2 global load, 3 group load, 4 dram amo, 5 group amo, 6 dmem overflow, 7 fdiv/fsqrt
- int_sb_clear_i  in  1  int scoreboard clear
- int_sb_clear_id_i  in  5  int register cleared
- float_sb_clear_i  in  1  float scoreboard clear
- float_sb_clear_id_i  in  5  float register cleared
- rec_v_o  out  1  record valid
- rec_fp_o  out  1  record regfile
- rec_rd_o  out  5  record register
- rec_class_o  out  3  record class
- rec_latency_o  out  ctr_width_p  cycles from issue to clear
- rec_yumi_i  in  1  consumer takes head record; legal only when rec_v_o=1
- outstanding_o  out  7  number of valid entries (0..64)
- orphan_count_o  out  cnt_width_p  clears with no pending entry
- drop_count_o  out  cnt_width_p  records lost to a full FIFO
- error_o  out  1  sticky: issue to a register already pending

## Operation
- Free-running cycle counter `now`, width ctr_width_p; reset 0; increments each cycle; wraps.
- Entry table: 64 entries (int 0..31, float 32..63), each holding {valid, class, ts}.
- Issue: entry[fp,rd] ← {1, class, now}. If the entry was already valid and is not cleared this cycle, set error_o and overwrite the entry.
- Clear (int and float independently): if the entry is valid, form record {fp, rd, class, now − ts mod 2^ctr_width_p}, then set valid←0. If the entry is not valid, orphan_count_o += 1 (saturating) and no record is formed.
- Same cycle, same register, issue and clear: the clear consumes the old entry and emits its record. The issue then installs the new entry. error_o is not set.
- Two records in one cycle (int and float clear): enqueue int before float. The FIFO accepts up to 2 pushes per cycle. Free space is computed after this cycle's yumi. Each record that does not fit increments drop_count_o; the int record has priority.
- Issue with register rd=0 and fp=0 is still tracked (the monitor does not filter).
- Counters saturate at all-ones. error_o stays 1 until reset.

## Timing
- Reset (async assert): all entries invalid, FIFO empty, now=0, rec_v_o=0, outstanding_o=0, both counters 0, error_o=0. Record fields are don't-care while rec_v_o=0. Reset asserted mid-operation discards pending entries and records immediately.
- Issue at cycle t, clear at cycle t+n gives latency n. The record is visible on rec_v_o at t+n+1 if the FIFO was empty.
- FIFO is registered; rec_* hold stable until yumi. Pop and push in the same cycle are allowed when full (pop frees space first).
- outstanding_o reflects registered state: updated the cycle after issue/clear.
- Latency correct across counter wrap, for any true latency below 2^ctr_width_p.

## Test plan
- Int dram load to x5 at cycle 10, int clear x5 at cycle 110 → one record {fp=0, rd=5, class=1, latency=100} at cycle 111; outstanding_o 1→0.
- Float fdiv to f3 and int idiv to x3 both issued, then both cleared in the same cycle → two records, int first, latencies correct; FIFO count 2.
- Clear x7 with no pending entry → orphan_count_o=1, no record; issue to x9 twice without a clear → error_o=1 and stays 1.
- els_p=8, yumi held low, 9 single clears → 8 records retained, drop_count_o=1; then yumi each cycle → 8 records drained in order.
- Issue x4 at now=2^32−3, clear 5 cycles later → latency=5 (wrap). Same-cycle clear+issue on x4 → record emitted, entry stays valid, error_o=0.
- Assert reset_i asynchronously with 3 entries pending and 2 FIFO records → outputs zero immediately; later clears of those registers count as orphans.
